bin_to_bcd_seq: RTL and testbench

//   Sequential binary-to-packed-BCD converter using shift-and-add-3 (double dabble).

---
 rtl/bin_to_bcd_seq.sv | 146 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3), one input bit per clock.
// Feeds the seven-segment driver directly; start/busy/done handshake, saturating overflow.
module bin_to_bcd_seq #(
    parameter int unsigned IN_WIDTH = 27,
    parameter int unsigned DIGITS   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);

    typedef logic [IN_WIDTH+3:0] wide_t;

    function automatic wide_t pow10_f();
        wide_t p;
        p = wide_t'(1);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            p = p * wide_t'(10);
        end
        return p;
    endfunction

    // Evaluated in 64 bits so a 10**DIGITS that outgrows wide_t still decides correctly.
    function automatic bit ovf_possible_f();
        logic [63:0] p;
        logic [63:0] lim;
        bit          ok;
        p   = 64'd1;
        lim = 64'd1 << IN_WIDTH;
        ok  = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (ok) begin
                p = p * 64'd10;
                if (p >= lim) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    localparam wide_t TEN_POW      = pow10_f();
    localparam bit    OVF_POSSIBLE = ovf_possible_f();

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_q,    state_d;
    logic [IN_WIDTH-1:0]  shreg_q,    shreg_d;
    logic [BCD_W-1:0]     scratch_q,  scratch_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;
    logic                 overflow_q, overflow_d;
    logic [BCD_W-1:0]     bcd_q,      bcd_d;

    logic [BCD_W-1:0]     adj;
    logic [BCD_W-1:0]     scratch_next;

    // Per-digit add-3 with no carry between digits, then the combined left shift.
    always_comb begin
        adj = scratch_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        scratch_next = {adj[BCD_W-2:0], shreg_q[IN_WIDTH-1]};
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        bcd_d      = bcd_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d    = bin_in;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(IN_WIDTH);
                    ovf_pend_d = OVF_POSSIBLE && ({4'b0000, bin_in} >= TEN_POW);
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = scratch_next;
                shreg_d   = {shreg_q[IN_WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d      = ovf_pend_q ? {DIGITS{4'h9}} : scratch_next;
                    overflow_d = ovf_pend_q;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            bcd_q      <= bcd_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign bcd_out  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: latency, results, overflow, busy-start, reset abort, back-to-back.
module tb_bin_to_bcd_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [26:0] bin_in;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] bcd_out;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.IN_WIDTH(27), .DIGITS(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd_out  (bcd_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Called just after a negedge; returns at the negedge following the accepting edge.
    task automatic launch(input logic [26:0] v);
        start  = 1'b1;
        bin_in = v;
        @(negedge clock);
        start  = 1'b0;
        bin_in = 27'h5A5A5A5;
    endtask

    // lat counts negedges since the start was driven; -1 on timeout.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 80) begin
            if (busy) busy_cnt++;
            @(negedge clock);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        bin_in = 27'd123;
        repeat (2) @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy, done, overflow} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {busy, done, overflow});
        end
        checks++;
        if (bcd_out !== 32'h0) begin
            errors++; $display("FAIL reset_bcd got %h want 00000000", bcd_out);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic;
        int lat, bc;
        launch(27'h69);
        wait_done(lat, bc);
        checks++;
        if (lat !== 28) begin
            errors++; $display("FAIL t1_latency got %0d want 28", lat);
        end
        checks++;
        if (bc !== 27) begin
            errors++; $display("FAIL t1_busy_cycles got %0d want 27", bc);
        end
        checks++;
        if (bcd_out !== 32'h0000_0105 || overflow !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL t1_result got %h ovf %b busy %b want 00000105 0 0", bcd_out, overflow, busy);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || bcd_out !== 32'h0000_0105) begin
            errors++; $display("FAIL t1_done_drop got done %b bcd %h want 0 00000105", done, bcd_out);
        end
    endtask

    task automatic test_values;
        logic [26:0] vin [5]  = '{27'd0, 27'd99_999_999, 27'd12_345_678, 27'd100_000_000, 27'd134_217_727};
        logic [31:0] vexp [5] = '{32'h0, 32'h9999_9999, 32'h1234_5678, 32'h9999_9999, 32'h9999_9999};
        logic        vovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            launch(vin[i]);
            wait_done(lat, bc);
            checks++;
            if (lat !== 28 || bcd_out !== vexp[i] || overflow !== vovf[i]) begin
                errors++;
                $display("FAIL value_%0d got lat %0d bcd %h ovf %b want 28 %h %b",
                         vin[i], lat, bcd_out, overflow, vexp[i], vovf[i]);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_overflow_clear;
        int lat, bc;
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_held_idle got %b want 1", overflow);
        end
        launch(27'd7);
        checks++;
        if (overflow !== 1'b1 || bcd_out !== 32'h9999_9999) begin
            errors++; $display("FAIL ovf_held_busy got %b %h want 1 99999999", overflow, bcd_out);
        end
        wait_done(lat, bc);
        checks++;
        if (lat !== 28 || bcd_out !== 32'h0000_0007 || overflow !== 1'b0) begin
            errors++; $display("FAIL t3_seven got lat %0d bcd %h ovf %b want 28 00000007 0", lat, bcd_out, overflow);
        end
        @(negedge clock);
    endtask

    task automatic test_busy_start;
        int dones = 0;
        int first = -1;
        launch(27'd42);
        for (int c = 1; c <= 60; c++) begin
            if (c == 10) begin
                start = 1'b1; bin_in = 27'd999;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dones++;
                if (first < 0) first = c;
            end
            @(negedge clock);
        end
        checks++;
        if (dones !== 1 || first !== 28) begin
            errors++; $display("FAIL t4_done_count got %0d at %0d want 1 at 28", dones, first);
        end
        checks++;
        if (bcd_out !== 32'h0000_0042) begin
            errors++; $display("FAIL t4_result got %h want 00000042", bcd_out);
        end
    endtask

    task automatic test_reset_abort;
        int dones = 0;
        int lat, bc;
        launch(27'd555);
        for (int c = 1; c <= 45; c++) begin
            reset = (c == 13);
            if (done) dones++;
            @(negedge clock);
        end
        checks++;
        if (dones !== 0 || busy !== 1'b0 || bcd_out !== 32'h0) begin
            errors++; $display("FAIL t5_abort got dones %0d busy %b bcd %h want 0 0 00000000", dones, busy, bcd_out);
        end
        launch(27'd555);
        wait_done(lat, bc);
        checks++;
        if (lat !== 28 || bcd_out !== 32'h0000_0555) begin
            errors++; $display("FAIL t5_rerun got lat %0d bcd %h want 28 00000555", lat, bcd_out);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back;
        int prev = 0;
        int cyc  = 0;
        start  = 1'b1;
        bin_in = 27'd1;
        for (int k = 1; k <= 3; k++) begin
            int waited = 0;
            do begin
                @(negedge clock);
                cyc++;
                waited++;
            end while (!done && waited < 80);
            checks++;
            if (!done || cyc - prev !== 28 || bcd_out !== 32'(k)) begin
                errors++;
                $display("FAIL b2b_%0d got done %b gap %0d bcd %h want 1 28 %h", k, done, cyc - prev, bcd_out, 32'(k));
            end
            prev   = cyc;
            bin_in = 27'(k + 1);
            if (k == 3) start = 1'b0;
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b_stop got busy %b want 0", busy);
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        @(negedge clock);
        test_reset;
        test_basic;
        test_values;
        test_overflow_clear;
        test_busy_start;
        test_reset_abort;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
